k054000_seq: RTL and testbench

Bus-master sequencer for the 054000 collision checker. Accepts one collision job (two hitboxes, 18 register bytes) over a valid/ready handshake. Writes each byte into the 054000 through its CS/NWR byte bus, reads back the result bit from the result register and presents it to the requester. Sits between the game-logic / CPU-replacement side and the k054000 core, replacing 68000 bus cycles.

---
 rtl/k054000_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_k054000_seq.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k054000_seq.sv
// k054000_seq
//   Bus-master sequencer for the 054000 collision checker. Takes one
//   18-byte collision job over a valid/ready handshake. Each byte is written
//   through the chip's CS/NWR byte bus in ascending slot order. The result
//   register (A=24, bit 0) is then read back and reported as a one-clock
//   res_valid pulse with res_hit.
//
// Parameters
//   WR_LEN   clocks NWR is held low per write (1..15)
//   RD_WAIT  clocks CS is held with NWR high before the result sample (1..15)
//
// Ports
//   clk, nRES          clock, synchronous active-low reset
//   job_valid/ready    job handshake; job_data slot k = job_data[8k+7:8k]
//   res_valid, res_hit result pulse and held result bit
//   busy               high in every state except IDLE
//   k_cs, k_nwr, k_a   054000 chip select (active-high), write strobe
//                      (active-low) and address A[5:1]
//   k_dout, k_doe      write data and its bus drive enable
//   k_din              read data from the 054000
//
// Build option
//   K054000_SEQ_DIRTY_EN  keep a shadow of the last written bytes and skip
//                         slots whose value is unchanged
module k054000_seq #(
  parameter int unsigned WR_LEN  = 2,
  parameter int unsigned RD_WAIT = 2
) (
  input  logic         clk,
  input  logic         nRES,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [143:0] job_data,
  output logic         res_valid,
  output logic         res_hit,
  output logic         busy,
  output logic         k_cs,
  output logic         k_nwr,
  output logic [4:0]   k_a,
  output logic [7:0]   k_dout,
  output logic         k_doe,
  input  logic [7:0]   k_din
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WSETUP,
    S_WSTROBE,
    S_WHOLD,
    S_WGAP,
    S_RSETUP,
    S_RGAP,
    S_DONE
  } state_t;

  localparam logic [4:0] RES_ADDR = 5'd24;

  state_t         state;
  state_t         state_nxt;
  logic [143:0]   job_q;
  logic [143:0]   src;
  logic [17:0]    need;
  logic [4:0]     slot;
  logic [3:0]     cnt;
  logic           ready_en;
  logic           rd_bit;
  logic           accept;
  logic           nxt_found;
  logic [4:0]     nxt_slot;
  logic [7:0]     nxt_byte;
  logic           load_w;
  logic           load_r;
  logic           unused_din;

  assign unused_din = ^k_din[7:1];

  function automatic logic [4:0] slot_addr(input logic [4:0] s);
    case (s)
      5'd0:    slot_addr = 5'd1;
      5'd1:    slot_addr = 5'd2;
      5'd2:    slot_addr = 5'd3;
      5'd3:    slot_addr = 5'd4;
      5'd4:    slot_addr = 5'd6;
      5'd5:    slot_addr = 5'd7;
      5'd6:    slot_addr = 5'd9;
      5'd7:    slot_addr = 5'd10;
      5'd8:    slot_addr = 5'd11;
      5'd9:    slot_addr = 5'd12;
      5'd10:   slot_addr = 5'd14;
      5'd11:   slot_addr = 5'd15;
      5'd12:   slot_addr = 5'd17;
      5'd13:   slot_addr = 5'd18;
      5'd14:   slot_addr = 5'd19;
      5'd15:   slot_addr = 5'd21;
      5'd16:   slot_addr = 5'd22;
      5'd17:   slot_addr = 5'd23;
      default: slot_addr = 5'd0;
    endcase
  endfunction

  assign job_ready = (state == S_IDLE) && ready_en;
  assign accept    = job_valid && job_ready;

  // In IDLE the first slot to write is decided from the incoming job, since
  // it is only latched at the accept edge itself.
  assign src = (state == S_IDLE) ? job_data : job_q;

`ifdef K054000_SEQ_DIRTY_EN
  logic [7:0]  shadow [18];
  logic [17:0] shadow_vld;

  always_comb begin
    need = '0;
    for (int unsigned k = 0; k < 18; k++) begin
      need[k] = !shadow_vld[k] || (src[8*k +: 8] != shadow[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!nRES) begin
      shadow_vld <= '0;
    end else if (state == S_WHOLD) begin
      shadow_vld[slot] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_WHOLD) begin
      shadow[slot] <= k_dout;
    end
  end
`else
  assign need = '1;
`endif

  // Lowest slot still to write: any slot from IDLE, only later slots after
  // a write has completed.
  always_comb begin
    nxt_found = 1'b0;
    nxt_slot  = '0;
    nxt_byte  = '0;
    for (int unsigned k = 0; k < 18; k++) begin
      if (!nxt_found && need[k] && ((state == S_IDLE) || (k > 32'(slot)))) begin
        nxt_found = 1'b1;
        nxt_slot  = 5'(k);
        nxt_byte  = src[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nRES) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = nxt_found ? S_WSETUP : S_RSETUP;
      S_WSETUP:  state_nxt = S_WSTROBE;
      S_WSTROBE: if (cnt == 4'd0) state_nxt = S_WHOLD;
      S_WHOLD:   state_nxt = S_WGAP;
      S_WGAP:    state_nxt = nxt_found ? S_WSETUP : S_RSETUP;
      S_RSETUP:  if (cnt == 4'd0) state_nxt = S_RGAP;
      S_RGAP:    state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign load_w = (state_nxt == S_WSETUP) && (state != S_WSETUP);
  assign load_r = (state_nxt == S_RSETUP) && (state != S_RSETUP);

  always_ff @(posedge clk) begin
    if (!nRES) begin
      ready_en <= 1'b0;
      job_q    <= '0;
      slot     <= '0;
      cnt      <= '0;
      k_a      <= '0;
      k_dout   <= '0;
      rd_bit   <= 1'b0;
      res_hit  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        job_q <= job_data;
      end
      // Address and data only move while CS is low (entering WSETUP/RSETUP).
      if (load_w) begin
        slot   <= nxt_slot;
        k_a    <= slot_addr(nxt_slot);
        k_dout <= nxt_byte;
      end
      if (load_r) begin
        k_a <= RES_ADDR;
      end
      if ((state_nxt == S_WSTROBE) && (state != S_WSTROBE)) begin
        cnt <= 4'(WR_LEN - 1);
      end else if (load_r) begin
        cnt <= 4'(RD_WAIT - 1);
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if ((state == S_RSETUP) && (cnt == 4'd0)) begin
        rd_bit <= k_din[0];
      end
      // Publish at the RGAP->DONE edge so res_hit moves with res_valid.
      if (state == S_RGAP) begin
        res_hit <= rd_bit;
      end
    end
  end

  assign k_cs      = (state == S_WSETUP) || (state == S_WSTROBE) ||
                     (state == S_WHOLD)  || (state == S_RSETUP);
  assign k_nwr     = (state != S_WSTROBE);
  assign k_doe     = (state == S_WSTROBE);
  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_DONE);

endmodule

// File: tb/tb_k054000_seq.sv
module tb_k054000_seq;

  localparam int unsigned WR_LEN  = 2;
  localparam int unsigned RD_WAIT = 2;
`ifdef K054000_SEQ_DIRTY_EN
  localparam bit DIRTY = 1'b1;
`else
  localparam bit DIRTY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         nRES;
  logic         job_valid;
  logic         job_ready;
  logic [143:0] job_data;
  logic         res_valid;
  logic         res_hit;
  logic         busy;
  logic         k_cs;
  logic         k_nwr;
  logic [4:0]   k_a;
  logic [7:0]   k_dout;
  logic         k_doe;
  logic [7:0]   k_din;

  k054000_seq #(.WR_LEN(WR_LEN), .RD_WAIT(RD_WAIT)) dut (
    .clk(clk), .nRES(nRES), .job_valid(job_valid), .job_ready(job_ready),
    .job_data(job_data), .res_valid(res_valid), .res_hit(res_hit),
    .busy(busy), .k_cs(k_cs), .k_nwr(k_nwr), .k_a(k_a), .k_dout(k_dout),
    .k_doe(k_doe), .k_din(k_din)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  int unsigned amap [18] = '{1, 2, 3, 4, 6, 7, 9, 10, 11, 12, 14, 15, 17, 18, 19, 21, 22, 23};

  // Stand-in 054000: a register file written by the bus; the result bit is
  // set when register 1 exceeds register 21.
  logic [7:0] regs [32];
  assign k_din = (k_cs && k_nwr && (k_a == 5'd24)) ? {7'd0, (regs[1] > regs[21])} : 8'h00;

  // Bus monitor
  logic [12:0] wr_q [$];
  int          strb_q [$];
  int          strobe_len = 0;
  int          stab_viol = 0;
  int          doe_viol = 0;
  logic        prev_doe = 1'b0;
  logic        prev_cs = 1'b0;
  logic [4:0]  prev_a = '0;
  logic [7:0]  prev_dout = '0;

  always @(negedge clk) begin
    if (k_doe && !prev_doe) begin
      wr_q.push_back({k_a, k_dout});
      strobe_len = 1;
    end else if (k_doe) begin
      strobe_len++;
    end
    if (!k_doe && prev_doe) strb_q.push_back(strobe_len);
    if (k_doe) regs[k_a] = k_dout;
    if (k_cs && prev_cs && ((k_a !== prev_a) || (k_dout !== prev_dout))) stab_viol++;
    if (k_doe !== (k_cs && !k_nwr)) doe_viol++;
    prev_doe  = k_doe;
    prev_cs   = k_cs;
    prev_a    = k_a;
    prev_dout = k_dout;
  end

  // Reference state: bytes last written to the chip
  logic [7:0]   sh [18];
  bit           sh_vld = 1'b0;
  logic [143:0] last_job = '0;

  function automatic logic [143:0] rand_job();
    logic [143:0] r;
    for (int i = 0; i < 18; i++) r[8*i +: 8] = 8'($urandom);
    return r;
  endfunction

  task automatic run_job(input logic [143:0] d, input bit junk);
    logic [12:0] exp_q [$];
    int unsigned exp_cyc;
    int          c;
    int          bad;
    bit          got;
    logic        exp_hit;
    logic        hit_prev;
    for (int k = 0; k < 18; k++) begin
      if (!DIRTY || !sh_vld || (d[8*k +: 8] != sh[k]))
        exp_q.push_back({5'(amap[k]), d[8*k +: 8]});
    end
    exp_cyc = exp_q.size() * (WR_LEN + 3) + RD_WAIT + 2;
    exp_hit = d[7:0] > d[8*15 +: 8];

    job_data  = d;
    job_valid = 1'b1;
    c = 0;
    while (!job_ready && c < 300) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (job_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL accept_wait: job_ready=%b required 1", job_ready);
      job_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!junk) job_valid = 1'b0;
    wr_q.delete();
    strb_q.delete();
    stab_viol = 0;
    doe_viol  = 0;
    hit_prev  = res_hit;
    bad = 0;
    got = 1'b0;
    for (c = 1; c <= int'(exp_cyc) + 50; c++) begin
      @(negedge clk);
      if (junk) job_data = rand_job();
      if (job_ready !== 1'b0 || busy !== 1'b1) bad++;
      if (res_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (res_hit !== hit_prev) bad++;
    end

    n_vec++;
    if (!got || c != int'(exp_cyc)) begin
      n_miss++;
      $display("FAIL latency: res_valid at cycle %0d (seen=%0b) required %0d", c, got, exp_cyc);
    end
    n_vec++;
    if (res_hit !== exp_hit) begin
      n_miss++;
      $display("FAIL res_hit: got %b required %b", res_hit, exp_hit);
    end
    n_vec++;
    if (bad != 0) begin
      n_miss++;
      $display("FAIL busy_flags: %0d cycles with bad job_ready/busy/res_hit, required 0", bad);
    end
    n_vec++;
    if (wr_q.size() != exp_q.size()) begin
      n_miss++;
      $display("FAIL write_count: got %0d required %0d", wr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (wr_q[i] !== exp_q[i]) begin
          n_miss++;
          $display("FAIL write[%0d]: got a=%0d d=%h required a=%0d d=%h", i,
                   wr_q[i][12:8], wr_q[i][7:0], exp_q[i][12:8], exp_q[i][7:0]);
          break;
        end
      end
    end
    n_vec++;
    foreach (strb_q[i]) begin
      if (strb_q[i] != int'(WR_LEN)) begin
        n_miss++;
        $display("FAIL strobe_len: got %0d required %0d", strb_q[i], WR_LEN);
        break;
      end
    end
    n_vec++;
    if (stab_viol != 0 || doe_viol != 0) begin
      n_miss++;
      $display("FAIL bus_protocol: addr/data moves under CS=%0d, doe errors=%0d, required 0/0",
               stab_viol, doe_viol);
    end

    @(negedge clk);
    n_vec++;
    if (job_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL ready_after_done: job_ready=%b res_valid=%b required 1/0", job_ready, res_valid);
    end
    for (int k = 0; k < 18; k++) sh[k] = d[8*k +: 8];
    sh_vld   = 1'b1;
    last_job = d;
  endtask

  task automatic test_reset();
    nRES = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (k_cs !== 1'b0 || k_nwr !== 1'b1 || k_doe !== 1'b0 || k_a !== 5'd0 || k_dout !== 8'd0) begin
      n_miss++;
      $display("FAIL reset_bus: cs=%b nwr=%b doe=%b a=%0d d=%h required 0 1 0 0 00",
               k_cs, k_nwr, k_doe, k_a, k_dout);
    end
    n_vec++;
    if (job_ready !== 1'b0 || res_valid !== 1'b0 || res_hit !== 1'b0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_flags: ready=%b valid=%b hit=%b busy=%b required 0 0 0 0",
               job_ready, res_valid, res_hit, busy);
    end
    nRES = 1'b1;
    @(negedge clk);
    n_vec++;
    if (job_ready !== 1'b1 || busy !== 1'b0 || k_cs !== 1'b0) begin
      n_miss++;
      $display("FAIL ready_after_reset: ready=%b busy=%b cs=%b required 1 0 0", job_ready, busy, k_cs);
    end
    sh_vld = 1'b0;
  endtask

  task automatic test_directed();
    logic [143:0] d;
    d = '0;
    run_job(d, 1'b0);
    d[7:0] = 8'hFF;
    run_job(d, 1'b0);
    d[8*15 +: 8] = 8'hFF;
    run_job(d, 1'b0);
  endtask

  task automatic test_random();
    logic [143:0] d;
    int unsigned  mode;
    for (int j = 0; j < 8; j++) begin
      mode = $urandom_range(0, 2);
      d = last_job;
      if (mode == 1) begin
        for (int n = 0; n < 2; n++) begin
          int unsigned s;
          s = $urandom_range(0, 17);
          d[8*s +: 8] = d[8*s +: 8] ^ 8'($urandom_range(1, 255));
        end
      end else if (mode == 2) begin
        d = rand_job();
      end
      run_job(d, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [143:0] a;
    logic [143:0] b;
    a = rand_job();
    b = rand_job();
    b[7:0] = 8'h00;
    run_job(a, 1'b1);
    run_job(b, 1'b0);
    run_job(b, 1'b0);
  endtask

  task automatic test_reset_mid_job();
    logic [143:0] d;
    int           n;
    int           c;
    int           bad;
    logic         pd;
    d = ~last_job;
    job_data  = d;
    job_valid = 1'b1;
    c = 0;
    while (!job_ready && c < 300) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk);
    #1;
    job_valid = 1'b0;
    n  = 0;
    pd = 1'b0;
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      if (k_doe && !pd) n++;
      pd = k_doe;
      if (n == 5) break;
    end
    n_vec++;
    if (n != 5) begin
      n_miss++;
      $display("FAIL fifth_strobe: saw %0d strobes required 5", n);
    end
    nRES = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (k_cs !== 1'b0 || k_nwr !== 1'b1 || k_doe !== 1'b0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL abort_bus: cs=%b nwr=%b doe=%b busy=%b required 0 1 0 0", k_cs, k_nwr, k_doe, busy);
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (res_valid !== 1'b0) bad++;
    end
    nRES = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (res_valid !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_miss++;
      $display("FAIL abort_no_result: %0d res_valid cycles required 0", bad);
    end
    sh_vld = 1'b0;
    run_job(d, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 8'h00;
    nRES      = 1'b0;
    job_valid = 1'b0;
    job_data  = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
